execute_mcycle_ctrl: RTL
========================

# execute_mcycle_ctrl

Parametrised controller for multi-cycle execute operations such as division, carry-less multiply, and future iterative units. It sits in the execute stage between the decoded instruction and NUNITS functional units. It drives one unit's enable while that unit is working, stalls the pipeline until the unit reports ready, and captures the result in a holding register. The result is written back exactly once, even when a downstream hold delays retirement. It adds flush abort, an optional timeout, and a per-operation cycle counter.

## Interface
- XLEN, 32, datapath width.
- NUNITS, 4, number of attached multi-cycle units (1..16).
- UW, $clog2(NUNITS) (min 1), unit select width (derived).
- TIMEOUT, 0, maximum BUSY cycles before abort; 0 disables the timeout.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- req_valid  in  1  a multi-cycle instruction is present in the execute stage.
- req_unit  in  UW  target unit index.
- req_waddr  in  5  destination register.
- req_clear  in  1  pipeline flush.
- req_hold  in  1  downstream hold (memory not ready); retirement is blocked.
- unit_enable  out  NUNITS  one-hot, level enable to the units.
- unit_ready  in  NUNITS  per-unit result-valid.
- unit_result  in  NUNITS*XLEN  results; unit i occupies bits [i*XLEN +: XLEN].
- stall  out  1  this block is holding the pipeline.
- wren  out  1  register-file write strobe.
- waddr  out  5  write address.
- wdata  out  XLEN  write data.
- err  out  1  one-cycle pulse on bad unit index or timeout.
- op_cycles  out  16  BUSY cycles of the last completed operation, saturating at 16'hFFFF.

## Operation
- States: IDLE, BUSY, DONE.
- Registers: state, sel (UW), waddr_q (5), res_q (XLEN), cnt (16), op_cycles.
- **IDLE**
  - On req_valid & ~req_clear & req_unit<NUNITS: latch sel and waddr_q, cnt<=0, go to BUSY, stall=1.
  - On req_valid & ~req_clear & req_unit>=NUNITS: err=1, stall=0, wren=0, stay in IDLE.
- **BUSY**
  - unit_enable[sel]=1, stall=1, cnt increments and saturates.
  - When unit_ready[sel]=1: res_q<=unit_result[sel], op_cycles<=cnt+1 (saturating), go to DONE.
  - Ready from non-selected units is ignored.
- **DONE**
  - unit_enable=0, stall=0.
  - If ~req_hold: wren=|waddr_q, waddr=waddr_q, wdata=res_q, go to IDLE.
  - If req_hold: wren=0, stay in DONE; res_q stays stable.
- **Timeout** (TIMEOUT>0): if BUSY and cnt==TIMEOUT-1 with no ready, err=1, go to IDLE, no write.
- **Clear** has priority over everything in every state:
  - unit_enable=0 and wren=0 combinationally in the same cycle.
  - Next state is IDLE.
  - A ready arriving in the clear cycle is discarded and op_cycles is not updated.
- waddr and wdata outputs read waddr_q and res_q at all times. Consumers qualify them with wren only.
- A new request cannot be accepted in the same cycle that DONE retires. It is accepted in the following IDLE cycle.

## Timing
- Reset values: state=IDLE, unit_enable=0, stall=0, wren=0, waddr=0, wdata=0, err=0, op_cycles=0, cnt=0.
- A request accepted at cycle t has unit_enable high from t+1.
- If the unit raises ready at cycle t+k (k>=1): DONE at t+k+1, write at t+k+1 when no hold is present.
- Minimum accept-to-write latency is 2 cycles.
- stall is high from t through t+k inclusive.
- Each accepted, unflushed, un-timed-out operation produces exactly one wren pulse, regardless of hold length.
- err is a single-cycle pulse: in IDLE for a bad unit index, at cycle t+TIMEOUT for a timeout.

## Test plan
- **Basic op:** NUNITS=4; req unit 2, waddr 5; unit 2 ready 3 cycles after enable with 32'hDEADBEEF -> stall high 4 cycles; single wren, waddr=5, wdata=DEADBEEF; op_cycles=3.
- **Hold in DONE:** same op with req_hold high 4 cycles after ready -> wren stays low for those 4 cycles, then exactly one pulse; wdata unchanged throughout.
- **Flush:** req_clear asserted in the 2nd BUSY cycle, and again in the cycle ready fires -> enable drops the same cycle, no wren, IDLE next cycle; op_cycles unchanged.
- **x0 and cross-talk:** req with waddr=0 -> wren=0 at completion. Ready on unit 1 while sel=3 -> ignored; stall persists.
- **Timeout and bad index:** TIMEOUT=8, unit never ready -> err at accept+8, IDLE, no write. NUNITS=3, req_unit=3 -> err pulse, stall=0, all enables 0.
- **Reset mid-op:** rst low in BUSY -> all outputs at reset values next cycle; a later ready is ignored.

Source files
------------

// File: rtl/execute_mcycle_ctrl.sv
// Execute-stage sequencer for multi-cycle functional units: enables the selected unit,
// stalls until it reports ready, holds the result and retires it exactly once.
module execute_mcycle_ctrl #(
  parameter int XLEN    = 32,
  parameter int NUNITS  = 4,
  parameter int UW      = (NUNITS > 1) ? $clog2(NUNITS) : 1,
  parameter int TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  input  logic [UW-1:0]          req_unit,
  input  logic [4:0]             req_waddr,
  input  logic                   req_clear,
  input  logic                   req_hold,
  output logic [NUNITS-1:0]      unit_enable,
  input  logic [NUNITS-1:0]      unit_ready,
  input  logic [NUNITS*XLEN-1:0] unit_result,
  output logic                   stall,
  output logic                   wren,
  output logic [4:0]             waddr,
  output logic [XLEN-1:0]        wdata,
  output logic                   err,
  output logic [15:0]            op_cycles
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state_reg, state_next;
  logic [UW-1:0]   sel_reg, sel_next;
  logic [4:0]      waddr_reg, waddr_next;
  logic [XLEN-1:0] res_reg, res_next;
  logic [15:0]     cnt_reg, cnt_next;
  logic [15:0]     op_cycles_reg, op_cycles_next;

  logic [NUNITS-1:0] sel_onehot;
  logic [XLEN-1:0]   masked_result [NUNITS];
  logic [XLEN-1:0]   res_mux;
  logic              ready_sel;
  logic              unit_ok;
  logic [15:0]       cnt_inc;
  logic              timeout_hit;

  // Decode the latched select once; both the enable and the result mux use it.
  generate
    for (genvar gi = 0; gi < NUNITS; gi++) begin : g_unit
      assign sel_onehot[gi]    = (sel_reg == UW'(gi));
      assign masked_result[gi] = sel_onehot[gi] ? unit_result[gi*XLEN +: XLEN] : '0;
    end
  endgenerate

  always_comb begin
    res_mux = '0;
    for (int i = 0; i < NUNITS; i++) begin
      res_mux = res_mux | masked_result[i];
    end
  end

  assign ready_sel   = |(unit_ready & sel_onehot);
  assign unit_ok     = (32'(req_unit) < 32'(NUNITS));
  assign cnt_inc     = (cnt_reg == 16'hFFFF) ? cnt_reg : cnt_reg + 16'd1;
  assign timeout_hit = (TIMEOUT > 0) && (cnt_reg == 16'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      sel_reg       <= '0;
      waddr_reg     <= '0;
      res_reg       <= '0;
      cnt_reg       <= '0;
      op_cycles_reg <= '0;
    end else begin
      state_reg     <= state_next;
      sel_reg       <= sel_next;
      waddr_reg     <= waddr_next;
      res_reg       <= res_next;
      cnt_reg       <= cnt_next;
      op_cycles_reg <= op_cycles_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    sel_next       = sel_reg;
    waddr_next     = waddr_reg;
    res_next       = res_reg;
    cnt_next       = cnt_reg;
    op_cycles_next = op_cycles_reg;
    unit_enable    = '0;
    stall          = 1'b0;
    wren           = 1'b0;
    err            = 1'b0;

    // A flush overrides every state; a ready seen in this cycle is dropped.
    if (req_clear) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid) begin
            if (unit_ok) begin
              sel_next   = req_unit;
              waddr_next = req_waddr;
              cnt_next   = '0;
              state_next = BUSY;
              stall      = 1'b1;
            end else begin
              err = 1'b1;
            end
          end
        end
        BUSY: begin
          unit_enable = sel_onehot;
          stall       = 1'b1;
          cnt_next    = cnt_inc;
          if (ready_sel) begin
            res_next       = res_mux;
            op_cycles_next = cnt_inc;
            state_next     = DONE;
          end else if (timeout_hit) begin
            err        = 1'b1;
            state_next = IDLE;
          end
        end
        DONE: begin
          // Writes to x0 retire silently.
          if (!req_hold) begin
            wren       = |waddr_reg;
            state_next = IDLE;
          end
        end
        default: state_next = IDLE;
      endcase
    end
  end

  assign waddr     = waddr_reg;
  assign wdata     = res_reg;
  assign op_cycles = op_cycles_reg;

endmodule
